// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS data-memory arbiter.
//   gnt_e       - which requester drives d_mem in the current cycle
//   arb_state_e - dmem_arbiter FSM state
//   STARVE_MAX_DEFAULT - default number of lost cycles before the external
//                        port is forced through (fairness build)
package mips_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_EXT  = 2'd2
  } gnt_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_ACK  = 1'b1
  } arb_state_e;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// arb_starve_cnt: saturating starvation counter with synchronous clear.
//   clock  in  clock, rising edge
//   reset  in  synchronous active-high reset, count -> 0
//   inc    in  count one lost cycle (saturates at MAX)
//   clr    in  clear count (wins over inc)
//   at_max out count has reached MAX
module arb_starve_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign at_max = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares d_mem between the core load/store path and an
// external loader/debug port. CPU has priority; the external port gets a
// one-cycle grant followed by a registered acknowledge cycle.
// Build option: define DMEM_ARB_FAIRNESS_EN to force the external port
// through after STARVE_MAX consecutive lost IDLE cycles.
// Ports:
//   clock, reset                     clock / synchronous active-high reset
//   cpu_req/we/addr/wdata            core access; cpu_rdata = mem_rdata
//   cpu_stall                        core lost arbitration this cycle
//   ext_req/we/addr/wdata            external access, held until ext_ack
//   ext_ack, ext_rdata               registered completion / read data
//   mem_we/re/addr/wdata, mem_rdata  d_mem side
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be in 1..15");
  end

  arb_state_e        state_q, state_d;
  logic              ext_ack_q, ext_ack_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  gnt_e              gnt;
  logic              force_ext;

`ifdef DMEM_ARB_FAIRNESS_EN
  logic starve_inc;

  // A lost cycle only counts while the request is actually eligible (IDLE).
  assign starve_inc = (state_q == ARB_IDLE) && ext_req && (gnt == GNT_CPU);

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clock  (clock),
    .reset  (reset),
    .inc    (starve_inc),
    .clr    (gnt == GNT_EXT),
    .at_max (force_ext)
  );
`else
  assign force_ext = 1'b0;
`endif

  // ext_req is ignored in ACK so a held request is not granted twice.
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (state_q == ARB_IDLE && ext_req && (!cpu_req || force_ext)) begin
        gnt = GNT_EXT;
      end else if (cpu_req) begin
        gnt = GNT_CPU;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    case (gnt)
      GNT_CPU: begin
        mem_we = cpu_we;
        mem_re = !cpu_we;
      end
      GNT_EXT: begin
        mem_we    = ext_we;
        mem_re    = !ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = cpu_req && (gnt == GNT_EXT);
  assign ext_ack   = ext_ack_q;
  assign ext_rdata = ext_rdata_q;

  always_comb begin
    state_d     = (gnt == GNT_EXT) ? ARB_ACK : ARB_IDLE;
    ext_ack_d   = (gnt == GNT_EXT);
    ext_rdata_d = ext_rdata_q;
    if (gnt == GNT_EXT && !ext_we) begin
      ext_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      ext_ack_q   <= 1'b0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ext_ack_q   <= ext_ack_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter that shares the single data memory (`d_mem`) between the MIPS core's load/store path and an external loader/debug port. It decides each cycle which requester drives the memory, stalls the core when it loses, and returns a registered acknowledge and read data to the external port. It sits between the core's ALU/write-back datapath and `d_mem` in `mips_top`, and replaces the direct wiring of `ALU_out` and `regRead2` into the memory.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 4: consecutive lost cycles after which the external port is forced through (fairness build only); range 1..15.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  core memory access this cycle (`MemRead | MemWrite`).
- `cpu_we`  in  1  core access is a write.
- `cpu_addr`  in  ADDR_W  core address (ALU result).
- `cpu_wdata`  in  DATA_W  core store data.
- `cpu_rdata`  out  DATA_W  load data to core; equals `mem_rdata`.
- `cpu_stall`  out  1  core must hold PC and suppress register/memory writes this cycle.
- `ext_req`  in  1  external access request; held until `ext_ack`.
- `ext_we`, `ext_addr`, `ext_wdata`  in  1/ADDR_W/DATA_W  external access; stable while `ext_req` is high.
- `ext_ack`  out  1  one-cycle pulse; external access has completed.
- `ext_rdata`  out  DATA_W  registered read data, valid while `ext_ack` is high.
- `mem_we`, `mem_re`  out  1  memory strobes.
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  muxed memory address and write data.
- `mem_rdata`  in  DATA_W  combinational read data from `d_mem`.

## Operation
- FSM states:
  - IDLE: normal arbitration.
  - ACK: the cycle after an external grant. `ext_ack`=1 and `ext_req` is ignored, so the same request cannot be granted twice.
- Grant is decided combinationally each cycle:
  - In ACK, or when `ext_req`=0: the CPU is granted if `cpu_req`=1, otherwise nothing is granted.
  - In IDLE with `ext_req`=1 and `cpu_req`=0: the external port is granted.
  - In IDLE with both requesting: the CPU wins, unless fairness forces the external port (see Configuration).
- CPU grant: memory is driven from `cpu_*`, `mem_we`=`cpu_we`, `mem_re`=!`cpu_we`.
- External grant: memory is driven from `ext_*`; the FSM goes to ACK; `ext_rdata` captures `mem_rdata` on reads and holds its previous value on writes.
- `cpu_stall` = `cpu_req` & external grant.
- No grant: `mem_we`=`mem_re`=0, and `mem_addr`/`mem_wdata` follow `cpu_*`.
- ACK always returns to IDLE after one cycle. Back-to-back external accesses therefore cost at least 2 cycles each.

## Timing
- Reset values: state IDLE, `ext_ack`=0, `ext_rdata`=0, starvation count 0.
- While `reset`=1, `mem_we`=`mem_re`=`cpu_stall`=0.
- CPU path has zero added latency: read data arrives in the same cycle, and the write commits at the next edge.
- External latency: the grant cycle N writes or reads memory; `ext_ack` and `ext_rdata` are valid in cycle N+1.
- The requester may drop `ext_req` or present a new request in the ACK cycle; a new request is first eligible in N+2.
- If reset is asserted in an ACK cycle, `ext_ack` drops on the next edge. A write granted before reset has already committed; the requester must reissue after reset.
- `cpu_stall` is combinational from `cpu_req`, `ext_req` and state; it must not feed back into `cpu_req` within the same cycle.

## Configuration
- `DMEM_ARB_FAIRNESS_EN` defined:
  - A saturating counter, width `$clog2(STARVE_MAX+1)`, increments in each IDLE cycle where `ext_req`=1 and the CPU is granted.
  - When the count equals `STARVE_MAX`, the external port is granted even if `cpu_req`=1, which stalls the core.
  - The counter clears on any external grant.
- Undefined: strict CPU priority and no counter. The external port can starve while the core issues continuous loads and stores.

## Structure
- Shared `mips_pkg` holds:
  - the grant enum (`GNT_NONE`, `GNT_CPU`, `GNT_EXT`);
  - the FSM state enum (`ARB_IDLE`, `ARB_ACK`);
  - the default `STARVE_MAX` constant.
- One sub-module: `arb_starve_cnt`, the saturating starvation counter with clear. It is instantiated only under `DMEM_ARB_FAIRNESS_EN`.

## Test plan
- CPU only: `cpu_req`=1, `cpu_we`=1, `cpu_addr`=0x10, `cpu_wdata`=0xDEADBEEF, then a read of 0x10 → `cpu_rdata`=0xDEADBEEF, `cpu_stall` never asserted, `ext_ack` stays 0.
- External only: `ext_req`=1, write of 0x20 with 0x12345678, then a read of 0x20 → `ext_ack` pulses 1 cycle after each grant, `ext_rdata`=0x12345678, each access takes 2 cycles.
- Contention, strict build: `cpu_req` and `ext_req` held high for 20 cycles → CPU granted every cycle, `cpu_stall`=0, `ext_ack` never asserts.
- Contention, fairness build (`STARVE_MAX`=4): same stimulus → external grant on the 5th cycle with `cpu_stall`=1 for that cycle only, `ext_ack` the next cycle, repeating every 6 cycles.
- Reset mid-operation: assert `reset` during the ACK cycle → `ext_ack`=0 and `ext_rdata`=0 after the edge, state IDLE. A request after reset completes normally.
- Ack-cycle reuse: keep `ext_req` high through ACK → no second grant in the ACK cycle; the next grant occurs in N+2.
